// File: rtl/ahb_bist_master.sv
// AHB-Lite memory BIST master: writes (addr ^ seed) over N words, reads back and compares.
// Define AHB_BIST_INV_PASS_EN to add a second write/read pass with inverted data.
module ahb_bist_master #(
    parameter int CW  = 16,
    parameter int ECW = 16
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    input  logic           start,
    input  logic [31:0]    base,
    input  logic [CW-1:0]  count,
    input  logic [31:0]    seed,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [31:0]    fail_addr,
    output logic [ECW-1:0] err_count,
    output logic [31:0]    HADDR,
    output logic [1:0]     HTRANS,
    output logic           HWRITE,
    output logic [2:0]     HSIZE,
    output logic [31:0]    HWDATA,
    input  logic [31:0]    HRDATA,
    input  logic           HREADY
);
    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_NSEQ = 2'b10;

`ifdef AHB_BIST_INV_PASS_EN
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_LAST, S_RD, S_RD_LAST, S_DONE, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_LAST, S_RD, S_RD_LAST, S_DONE} state_t;
`endif

    state_t         state, state_nx;
    logic [31:0]    base_q, seed_q, raddr_q;
    logic [31:0]    base_nx, seed_nx, raddr_nx;
    logic [CW-1:0]  cnt_q, idx_q, cnt_nx, idx_nx;
    logic           rdv_q, rdv_nx;
    logic           busy_nx, done_nx, pass_nx, hwrite_nx;
    logic [31:0]    fail_nx, haddr_nx, hwdata_nx;
    logic [ECW-1:0] err_nx;
    logic [1:0]     htrans_nx;
    logic           cmp_en, finish, last_beat;
    logic [31:0]    inv_mask;

`ifdef AHB_BIST_INV_PASS_EN
    logic inv_q, inv_nx;
    assign inv_mask = {32{inv_q}};
`else
    assign inv_mask = 32'h0;
`endif

    assign HSIZE     = 3'b010;
    assign last_beat = (idx_q == cnt_q - CW'(1));

    always_comb begin
        state_nx  = state;
        base_nx   = base_q;
        seed_nx   = seed_q;
        cnt_nx    = cnt_q;
        idx_nx    = idx_q;
        raddr_nx  = raddr_q;
        rdv_nx    = rdv_q;
        busy_nx   = busy;
        done_nx   = 1'b0;
        pass_nx   = pass;
        fail_nx   = fail_addr;
        err_nx    = err_count;
        haddr_nx  = HADDR;
        htrans_nx = HTRANS;
        hwrite_nx = HWRITE;
        hwdata_nx = HWDATA;
        cmp_en    = 1'b0;
        finish    = 1'b0;
`ifdef AHB_BIST_INV_PASS_EN
        inv_nx    = inv_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    base_nx = base & ~32'h3;
                    seed_nx = seed;
                    cnt_nx  = count;
                    fail_nx = '0;
                    err_nx  = '0;
                    pass_nx = 1'b0;
`ifdef AHB_BIST_INV_PASS_EN
                    inv_nx  = 1'b0;
`endif
                    if (count != '0) begin
                        busy_nx   = 1'b1;
                        haddr_nx  = base & ~32'h3;
                        htrans_nx = TR_NSEQ;
                        hwrite_nx = 1'b1;
                        idx_nx    = '0;
                        state_nx  = S_WR;
                    end else begin
                        // empty range: report a trivial pass without touching the bus
                        done_nx  = 1'b1;
                        pass_nx  = 1'b1;
                        state_nx = S_DONE;
                    end
                end
            end
            S_WR: begin
                if (HREADY) begin
                    hwdata_nx = HADDR ^ seed_q ^ inv_mask;
                    idx_nx    = idx_q + CW'(1);
                    if (last_beat) begin
                        htrans_nx = TR_IDLE;
                        state_nx  = S_WR_LAST;
                    end else begin
                        haddr_nx = HADDR + 32'd4;
                    end
                end
            end
            S_WR_LAST: begin
                if (HREADY) begin
                    haddr_nx  = base_q;
                    htrans_nx = TR_NSEQ;
                    hwrite_nx = 1'b0;
                    idx_nx    = '0;
                    rdv_nx    = 1'b0;
                    state_nx  = S_RD;
                end
            end
            S_RD: begin
                if (HREADY) begin
                    // first read address phase has no data phase ahead of it
                    cmp_en   = rdv_q;
                    raddr_nx = HADDR;
                    rdv_nx   = 1'b1;
                    idx_nx   = idx_q + CW'(1);
                    if (last_beat) begin
                        htrans_nx = TR_IDLE;
                        state_nx  = S_RD_LAST;
                    end else begin
                        haddr_nx = HADDR + 32'd4;
                    end
                end
            end
            S_RD_LAST: begin
                if (HREADY) begin
                    cmp_en = 1'b1;
`ifdef AHB_BIST_INV_PASS_EN
                    if (!inv_q) begin
                        inv_nx   = 1'b1;
                        state_nx = S_GAP;
                    end else begin
                        finish = 1'b1;
                    end
`else
                    finish = 1'b1;
`endif
                end
            end
`ifdef AHB_BIST_INV_PASS_EN
            S_GAP: begin
                haddr_nx  = base_q;
                htrans_nx = TR_NSEQ;
                hwrite_nx = 1'b1;
                idx_nx    = '0;
                state_nx  = S_WR;
            end
`endif
            default: state_nx = S_IDLE;
        endcase

        if (cmp_en && (HRDATA != (raddr_q ^ seed_q ^ inv_mask))) begin
            if (err_count == '0) fail_nx = raddr_q;
            if (err_count != '1) err_nx = err_count + ECW'(1);
        end

        if (finish) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            pass_nx  = (err_nx == '0);
            state_nx = S_DONE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            base_q    <= '0;
            seed_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            raddr_q   <= '0;
            rdv_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
            HADDR     <= '0;
            HTRANS    <= TR_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
`ifdef AHB_BIST_INV_PASS_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            base_q    <= base_nx;
            seed_q    <= seed_nx;
            cnt_q     <= cnt_nx;
            idx_q     <= idx_nx;
            raddr_q   <= raddr_nx;
            rdv_q     <= rdv_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            fail_addr <= fail_nx;
            err_count <= err_nx;
            HADDR     <= haddr_nx;
            HTRANS    <= htrans_nx;
            HWRITE    <= hwrite_nx;
            HWDATA    <= hwdata_nx;
`ifdef AHB_BIST_INV_PASS_EN
            inv_q     <= inv_nx;
`endif
        end
    end

endmodule

// File: doc/ahb_bist_master.md
Name: ahb_bist_master

Overview:
- AHB-Lite master placed directly upstream of the AHB SRAM slave. It drives HADDR/HTRANS/HWRITE/HSIZE/HWDATA and consumes HRDATA/HREADY.
- On a start pulse it writes a deterministic pattern to N consecutive words, then reads them back and compares.
- Reports pass/fail, first failing address and mismatch count.
- Used as an on-chip memory self-test and as a bus-level stimulus source for the SRAM path.

Parameters:
- CW, 16, width of the word-count input.
- ECW, 16, width of the saturating error counter.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start request; sampled only in IDLE.
- base  in  32  start byte address; bits [1:0] ignored (forced 0).
- count  in  CW  number of 32-bit words to test.
- seed  in  32  pattern seed.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  1 if no mismatches; valid from done until next start.
- fail_addr  out  32  address of the first mismatch; 0 if none.
- err_count  out  ECW  mismatch count, saturating at all-ones.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HWRITE  out  1  AHB write flag.
- HSIZE  out  3  constant 3'b010 (word).
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready; transfers advance only when high.

Behaviour:
- All outputs registered.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, pass=0, fail_addr=0, err_count=0.
- Pattern: data(i) = addr(i) XOR seed, where addr(i) = base + 4*i, modulo 2^32 (wraps past 0xFFFF_FFFC).
- FSM states: IDLE, WR, WR_LAST, RD, RD_LAST, DONE.
- IDLE, start=1 and count!=0 at an edge:
  - Latch base/seed/count; clear pass/fail_addr/err_count.
  - Set busy; go to WR with HTRANS=NONSEQ, HWRITE=1, HADDR=addr(0) in the next cycle.
- IDLE, start=1 and count=0: go to DONE directly (no bus activity). pass=1 with the done pulse.
- WR (pipelined single transfers):
  - Each edge with HREADY=1 completes the current address phase.
  - HWDATA takes data of that address for the following data phase.
  - HADDR advances to the next address.
  - After the last address is accepted: HTRANS=IDLE, state=WR_LAST.
- WR_LAST:
  - HTRANS stays IDLE while the last write data phase runs.
  - When HREADY=1 ends it: issue addr(0) as NONSEQ read (HWRITE=0), go to RD.
  - This guarantees at least one idle cycle between the last write and the first read.
- RD:
  - Address phases are pipelined as in WR.
  - On each edge with HREADY=1 ending a read data phase, compare HRDATA against the expected data of that beat.
  - On mismatch: err_count+1 (saturating); if it is the first mismatch, fail_addr=beat address.
  - After the last read address is accepted: HTRANS=IDLE, go to RD_LAST.
- RD_LAST: final compare on HREADY=1, then go to DONE.
- DONE:
  - One cycle: done=1, pass=(err_count==0 including final compare), busy=0.
  - Then IDLE.
- HREADY=0: HADDR/HTRANS/HWRITE/HWDATA held stable; no counters advance; no compare.
- start while busy: ignored.
- Timing with HREADY always 1, N words:
  - Write addresses in cycles 1..N after the start edge.
  - Read addresses in cycles N+2..2N+1.
  - done high in cycle 2N+3.
- Reset asserted mid-test: all outputs return to reset values immediately (asynchronous). The in-flight transfer is abandoned and the FSM returns to IDLE.

Optional Feature:
- Macro AHB_BIST_INV_PASS_EN.
- Defined:
  - After RD_LAST, run a second write+read pass over the same range with data = ~(addr XOR seed).
  - Same idle-cycle rules apply; err_count/fail_addr accumulate across both passes.
  - done timing becomes 4N+6 cycles.
- Undefined: single pass only; no extra states or logic.

Test Plan:
- base=0x0, count=4, seed=0 with AHB SRAM slave -> writes 0x0,0x4,0x8,0xC at those addresses; done in cycle 11; pass=1; err_count=0; fail_addr=0.
- base=0x100, count=16, seed=0xA5A5A5A5 -> word 0x104 holds 0xA5A5A4A1; pass=1.
- Same as above, with the bench corrupting SRAMRDATA for address 0x108 (bit 0 flipped) -> pass=0, fail_addr=0x108, err_count=1.
- count=0, start pulse -> HTRANS never NONSEQ; done one cycle later; pass=1.
- Slave model inserting 2 wait states per beat, base=0x40, count=8 -> HADDR/HWDATA held across waits; pass=1; no duplicate or skipped beats.
- HRESETn low during WR beat 3 of 16 -> HTRANS=IDLE and busy=0 at once. A subsequent start with base=0x0, count=2 completes with pass=1.
